// File: rtl/idct_depermute.sv
// ---------------------------------------------------------------------------
// idct_depermute
// Input stage of the inverse 1-D DCT-II. Collects one natural-order row of
// N = 4/8/16/32 signed coefficients over a valid/ready stream, then presents
// the row split into the even/odd butterfly groups y2e, y2o, y4o, y8o, y16o.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input beat handshake, BEAT coefficients per beat
//   in_coef              lane i = coefficient beat*BEAT+i
//   in_n                 size code (0:4 1:8 2:16 3:32), sampled on first beat
//   out_valid/out_ready  grouped-row handshake
//   out_n                size code of the presented row
//   y2e,y2o,y4o,y8o,y16o grouped coefficients, element j at [W*j +: W]
// ---------------------------------------------------------------------------
module idct_depermute #(
  parameter int unsigned BEAT = 4,
  parameter int unsigned W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W*BEAT-1:0] in_coef,
  input  logic [1:0]        in_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_n,
  output logic [2*W-1:0]    y2e,
  output logic [2*W-1:0]    y2o,
  output logic [4*W-1:0]    y4o,
  output logic [8*W-1:0]    y8o,
  output logic [16*W-1:0]   y16o
);

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned BEAT_SH = $clog2(BEAT);

  typedef enum logic {FILL, EMIT} state_t;

  state_t         state;
  logic [AW-1:0]  cnt;
  logic [1:0]     row_n;
  logic [W-1:0]   buf_q [DEPTH];

  logic           accept_c;
  logic [1:0]     cur_n_c;
  logic [AW-1:0]  last_c;

  // The first beat uses the incoming size code, later beats the latched one.
  always_comb begin
    accept_c = in_valid & in_ready;
    cur_n_c  = (cnt == '0) ? in_n : row_n;
    last_c   = AW'((32'd4 << cur_n_c) >> BEAT_SH) - AW'(1);
  end

  // Row FSM: FILL accepts beats, EMIT presents the grouped row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      row_n     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept_c) begin
            if (cnt == '0) begin
              row_n <= in_n;
            end
            if (cnt == last_c) begin
              cnt       <= '0;
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= FILL;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient buffer; beat b lane i lands in entry b*BEAT+i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        buf_q[k] <= '0;
      end
    end else if (accept_c) begin
      for (int i = 0; i < int'(BEAT); i++) begin
        buf_q[AW'(32'(cnt) * BEAT + 32'(i))] <= in_coef[W*i +: W];
      end
    end
  end

  assign out_n = row_n;

  logic [W-1:0] g2e  [2];
  logic [W-1:0] g2o  [2];
  logic [W-1:0] g4o  [4];
  logic [W-1:0] g8o  [8];
  logic [W-1:0] g16o [16];

  // Even/odd routing; groups beyond the row size stay zero regardless of
  // whatever an earlier, longer row left in the buffer.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      g2e[j] = '0;
      g2o[j] = '0;
    end
    for (int j = 0; j < 4; j++) begin
      g4o[j] = '0;
    end
    for (int j = 0; j < 8; j++) begin
      g8o[j] = '0;
    end
    for (int j = 0; j < 16; j++) begin
      g16o[j] = '0;
    end
    case (row_n)
      2'd0: begin
        for (int j = 0; j < 2; j++) begin
          g2e[j] = buf_q[AW'(2 * j)];
          g2o[j] = buf_q[AW'(1 + 2 * j)];
        end
      end
      2'd1: begin
        for (int j = 0; j < 2; j++) begin
          g2e[j] = buf_q[AW'(4 * j)];
          g2o[j] = buf_q[AW'(2 + 4 * j)];
        end
        for (int j = 0; j < 4; j++) begin
          g4o[j] = buf_q[AW'(1 + 2 * j)];
        end
      end
      2'd2: begin
        for (int j = 0; j < 2; j++) begin
          g2e[j] = buf_q[AW'(8 * j)];
          g2o[j] = buf_q[AW'(4 + 8 * j)];
        end
        for (int j = 0; j < 4; j++) begin
          g4o[j] = buf_q[AW'(2 + 4 * j)];
        end
        for (int j = 0; j < 8; j++) begin
          g8o[j] = buf_q[AW'(1 + 2 * j)];
        end
      end
      default: begin
        for (int j = 0; j < 2; j++) begin
          g2e[j] = buf_q[AW'(16 * j)];
          g2o[j] = buf_q[AW'(8 + 16 * j)];
        end
        for (int j = 0; j < 4; j++) begin
          g4o[j] = buf_q[AW'(4 + 8 * j)];
        end
        for (int j = 0; j < 8; j++) begin
          g8o[j] = buf_q[AW'(2 + 4 * j)];
        end
        for (int j = 0; j < 16; j++) begin
          g16o[j] = buf_q[AW'(1 + 2 * j)];
        end
      end
    endcase
  end

  // Lane packing of the groups onto the flat output buses.
  for (genvar g = 0; g < 2; g++) begin : g_pack2
    assign y2e[W*g +: W] = g2e[g];
    assign y2o[W*g +: W] = g2o[g];
  end
  for (genvar g = 0; g < 4; g++) begin : g_pack4
    assign y4o[W*g +: W] = g4o[g];
  end
  for (genvar g = 0; g < 8; g++) begin : g_pack8
    assign y8o[W*g +: W] = g8o[g];
  end
  for (genvar g = 0; g < 16; g++) begin : g_pack16
    assign y16o[W*g +: W] = g16o[g];
  end

endmodule

// File: tb/tb_idct_depermute.sv
// ---------------------------------------------------------------------------
// tb_idct_depermute
// Directed bench: a BEAT=4 instance (dut) and a BEAT=1 instance (dut1)
// share clock and reset; each scenario task checks its own expectations.
// ---------------------------------------------------------------------------
module tb_idct_depermute;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // BEAT=4 instance
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [63:0]  in_coef;
  logic [1:0]   in_n, out_n;
  logic [31:0]  y2e, y2o;
  logic [63:0]  y4o;
  logic [127:0] y8o;
  logic [255:0] y16o;

  // BEAT=1 instance
  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [15:0]  in_coef1;
  logic [1:0]   in_n1, out_n1;
  logic [31:0]  y2e1, y2o1;
  logic [63:0]  y4o1;
  logic [127:0] y8o1;
  logic [255:0] y16o1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_in_acc = -1;
  int last_out_hs = -1;

  idct_depermute #(.BEAT(4), .W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_coef(in_coef), .in_n(in_n), .out_valid(out_valid), .out_ready(out_ready),
    .out_n(out_n), .y2e(y2e), .y2o(y2o), .y4o(y4o), .y8o(y8o), .y16o(y16o)
  );

  idct_depermute #(.BEAT(1), .W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_coef(in_coef1), .in_n(in_n1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_n(out_n1), .y2e(y2e1), .y2o(y2o1), .y4o(y4o1), .y8o(y8o1), .y16o(y16o1)
  );

  // Handshake timestamps of the BEAT=4 instance
  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) last_in_acc = cyc;
    if (out_valid && out_ready) last_out_hs = cyc;
  end

  function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic send4(input logic [63:0] coef, input logic [1:0] n);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_coef = coef; in_n = n;
    while (in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL send4_timeout in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1 in_valid = 1'b0;
    end
  endtask

  task automatic send1(input logic [15:0] coef, input logic [1:0] n);
    int t = 0;
    @(negedge clk);
    in_valid1 = 1'b1; in_coef1 = coef; in_n1 = n;
    while (in_ready1 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL send1_timeout in_ready=%b required 1", in_ready1);
      in_valid1 = 1'b0;
    end else begin
      @(posedge clk); #1 in_valid1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_n !== 2'd0) begin errors++; $display("FAIL rst_out_n got %0d exp 0", out_n); end
    checks++; if ({y2e, y2o, y4o} !== '0) begin errors++; $display("FAIL rst_y_low got %h exp 0", {y2e, y2o, y4o}); end
    checks++; if ({y8o, y16o} !== '0) begin errors++; $display("FAIL rst_y_high got %h exp 0", {y8o, y16o}); end
    checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_dut1 in_ready=%b out_valid=%b exp 1/0", in_ready1, out_valid1); end
    rst = 1'b0;
  endtask

  task automatic handshake4(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_hs_out_valid got %b exp 0", tag, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_hs_in_ready got %b exp 1", tag, in_ready); end
  endtask

  // 32-point ramp c[k]=k+1; in_n on later beats is 0 and must be ignored
  task automatic test_n3_ramp();
    logic [127:0] e8;
    logic [255:0] e16;
    for (int j = 0; j < 8; j++) e8[16*j +: 16] = 16'(3 + 4 * j);
    for (int j = 0; j < 16; j++) e16[16*j +: 16] = 16'(2 + 2 * j);
    for (int b = 0; b < 8; b++) begin
      send4(pack4(4*b+1, 4*b+2, 4*b+3, 4*b+4), (b == 0) ? 2'd3 : 2'd0);
      if (b == 6) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL n3_early_valid got %b exp 0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL n3_out_valid got %b exp 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL n3_in_ready got %b exp 0", in_ready); end
    checks++; if (out_n !== 2'd3) begin errors++; $display("FAIL n3_out_n got %0d exp 3", out_n); end
    checks++; if (y2e !== {16'd17, 16'd1}) begin errors++; $display("FAIL n3_y2e got %h exp %h", y2e, {16'd17, 16'd1}); end
    checks++; if (y2o !== {16'd25, 16'd9}) begin errors++; $display("FAIL n3_y2o got %h exp %h", y2o, {16'd25, 16'd9}); end
    checks++; if (y4o !== {16'd29, 16'd21, 16'd13, 16'd5}) begin errors++; $display("FAIL n3_y4o got %h", y4o); end
    checks++; if (y8o[15:0] !== 16'd3 || y8o[127:112] !== 16'd31) begin errors++; $display("FAIL n3_y8o_ends got %0d/%0d exp 3/31", y8o[15:0], y8o[127:112]); end
    checks++; if (y8o !== e8) begin errors++; $display("FAIL n3_y8o got %h exp %h", y8o, e8); end
    checks++; if (y16o[15:0] !== 16'd2 || y16o[255:240] !== 16'd32) begin errors++; $display("FAIL n3_y16o_ends got %0d/%0d exp 2/32", y16o[15:0], y16o[255:240]); end
    checks++; if (y16o !== e16) begin errors++; $display("FAIL n3_y16o got %h exp %h", y16o, e16); end
    handshake4("n3");
  endtask

  // Single-beat n=0 row over a buffer still holding the ramp
  task automatic test_n0_single();
    send4(pack4(10, 20, 30, 40), 2'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL n0_out_valid got %b exp 1", out_valid); end
    checks++; if (out_n !== 2'd0) begin errors++; $display("FAIL n0_out_n got %0d exp 0", out_n); end
    checks++; if (y2e !== {16'd30, 16'd10}) begin errors++; $display("FAIL n0_y2e got %h exp %h", y2e, {16'd30, 16'd10}); end
    checks++; if (y2o !== {16'd40, 16'd20}) begin errors++; $display("FAIL n0_y2o got %h exp %h", y2o, {16'd40, 16'd20}); end
    checks++; if ({y4o, y8o, y16o} !== '0) begin errors++; $display("FAIL n0_unused got %h exp 0", {y4o, y8o, y16o}); end
    handshake4("n0");
  endtask

  // n=2 negative ramp, held in EMIT with junk offered on the input
  task automatic test_hold();
    logic [63:0]  e4;
    logic [127:0] e8;
    for (int j = 0; j < 4; j++) e4[16*j +: 16] = 16'(-(2 + 4 * j));
    for (int j = 0; j < 8; j++) e8[16*j +: 16] = 16'(-(1 + 2 * j));
    for (int b = 0; b < 4; b++) send4(pack4(-4*b, -(4*b+1), -(4*b+2), -(4*b+3)), (b == 0) ? 2'd2 : 2'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_out_valid got %b exp 1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got %b exp 0", c, in_ready); end
      checks++; if (out_n !== 2'd2) begin errors++; $display("FAIL hold%0d_out_n got %0d exp 2", c, out_n); end
      checks++; if (y2e !== {16'(-8), 16'd0}) begin errors++; $display("FAIL hold%0d_y2e got %h", c, y2e); end
      checks++; if (y2o !== {16'(-12), 16'(-4)}) begin errors++; $display("FAIL hold%0d_y2o got %h", c, y2o); end
      checks++; if (y4o !== e4) begin errors++; $display("FAIL hold%0d_y4o got %h exp %h", c, y4o, e4); end
      checks++; if (y8o !== e8 || y8o[127:112] !== 16'hFFF1) begin errors++; $display("FAIL hold%0d_y8o got %h exp %h", c, y8o, e8); end
      checks++; if (y16o !== '0) begin errors++; $display("FAIL hold%0d_y16o got %h exp 0", c, y16o); end
      in_valid = 1'b1; in_coef = 64'h5A5A_5A5A_5A5A_5A5A; in_n = 2'd3;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", out_valid); end
  endtask

  // BEAT=1, n=1, later in_n forced to 3, with idle gaps
  task automatic test_beat1();
    for (int k = 0; k < 8; k++) begin
      send1(16'(100 + k), (k == 0) ? 2'd1 : 2'd3);
      if (k == 2 || k == 5) begin
        @(negedge clk); in_coef1 = 16'hBEEF; in_n1 = 2'd3;
        @(negedge clk);
      end
      if (k == 6) begin
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL b1_early_valid got %b exp 0", out_valid1); end
      end
    end
    checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL b1_out_valid got %b exp 1", out_valid1); end
    checks++; if (out_n1 !== 2'd1) begin errors++; $display("FAIL b1_out_n got %0d exp 1", out_n1); end
    checks++; if (y4o1 !== {16'd107, 16'd105, 16'd103, 16'd101}) begin errors++; $display("FAIL b1_y4o got %h", y4o1); end
    checks++; if (y2e1 !== {16'd104, 16'd100}) begin errors++; $display("FAIL b1_y2e got %h", y2e1); end
    checks++; if (y2o1 !== {16'd106, 16'd102}) begin errors++; $display("FAIL b1_y2o got %h", y2o1); end
    checks++; if ({y8o1, y16o1} !== '0) begin errors++; $display("FAIL b1_unused got %h exp 0", {y8o1, y16o1}); end
    @(negedge clk); out_ready1 = 1'b1;
    @(posedge clk); #1 out_ready1 = 1'b0;
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL b1_hs valid=%b ready=%b exp 0/1", out_valid1, in_ready1); end
  endtask

  // Reset three beats into an n=3 row, then a clean n=0 row
  task automatic test_reset_midrow();
    for (int b = 0; b < 3; b++) send4(pack4(4*b+1, 4*b+2, 4*b+3, 4*b+4), 2'd3);
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mrst_hs valid=%b ready=%b exp 0/1", out_valid, in_ready); end
    checks++; if (out_n !== 2'd0) begin errors++; $display("FAIL mrst_out_n got %0d exp 0", out_n); end
    checks++; if ({y2e, y2o, y4o, y8o, y16o} !== '0) begin errors++; $display("FAIL mrst_y got %h exp 0", {y2e, y2o, y4o}); end
    @(negedge clk); rst = 1'b0;
    send4(pack4(1, 2, 3, 4), 2'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_row_valid got %b exp 1", out_valid); end
    checks++; if (y2e !== {16'd3, 16'd1} || y2o !== {16'd4, 16'd2}) begin errors++; $display("FAIL mrst_row y2e=%h y2o=%h", y2e, y2o); end
    checks++; if ({y4o, y8o, y16o} !== '0 || out_n !== 2'd0) begin errors++; $display("FAIL mrst_row_unused out_n=%0d", out_n); end
    handshake4("mrst");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send4(pack4(11, 12, 13, 14), 2'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_a_valid got %b exp 1", out_valid); end
    checks++; if (y2e !== {16'd13, 16'd11} || y2o !== {16'd14, 16'd12}) begin errors++; $display("FAIL b2b_a y2e=%h y2o=%h", y2e, y2o); end
    send4(pack4(21, 22, 23, 24), 2'd0);
    checks++; if (last_in_acc - last_out_hs !== 1) begin errors++; $display("FAIL b2b_gap got %0d exp 1", last_in_acc - last_out_hs); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_b_valid got %b exp 1", out_valid); end
    checks++; if (y2e !== {16'd23, 16'd21} || y2o !== {16'd24, 16'd22}) begin errors++; $display("FAIL b2b_b y2e=%h y2o=%h", y2e, y2o); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_b_hs got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_coef = '0; in_n = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_coef1 = '0; in_n1 = '0; out_ready1 = 1'b0;
    test_reset();
    test_n3_ramp();
    test_n0_single();
    test_hold();
    test_beat1();
    test_reset_midrow();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
